sdram_req_sched: RTL and testbench

Request-side scheduler for the SDRAM read/write port. It watches the write-FIFO fill level and the read-FIFO free space, then raises burst write or read requests toward the SDRAM controller. It holds each request until acknowledged and counts acknowledged words. After each burst it advances and wraps the write and read addresses. It sits between the user FIFOs and the SDRAM controller, and it is the requester counterpart of the controller's request/acknowledge port.

---
 rtl/sdram_req_sched_if.sv | 26 ++
 rtl/sdram_req_sched.sv | 143 ++++++++++++++
 tb/tb_sdram_req_sched.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_req_sched_if.sv
// Request/acknowledge port between the burst scheduler (master) and the SDRAM controller (slave).
// Carries the burst requests, burst lengths, start addresses and per-word acknowledges.
interface sdram_req_sched_if #(
  parameter int ADDR_W = 24
);
  logic              sdram_wr_req;
  logic              sdram_rd_req;
  logic [9:0]        sdram_wr_burst;
  logic [9:0]        sdram_rd_burst;
  logic [ADDR_W-1:0] sdram_wr_addr;
  logic [ADDR_W-1:0] sdram_rd_addr;
  logic              sdram_wr_ack;
  logic              sdram_rd_ack;

  modport master (
    output sdram_wr_req, sdram_rd_req, sdram_wr_burst, sdram_rd_burst,
           sdram_wr_addr, sdram_rd_addr,
    input  sdram_wr_ack, sdram_rd_ack
  );

  modport slave (
    input  sdram_wr_req, sdram_rd_req, sdram_wr_burst, sdram_rd_burst,
           sdram_wr_addr, sdram_rd_addr,
    output sdram_wr_ack, sdram_rd_ack
  );
endinterface

// File: rtl/sdram_req_sched.sv
// Burst request scheduler: raises write/read burst requests from FIFO levels, holds them until
// acknowledged, counts acknowledged words and advances wrapping circular-buffer addresses.
module sdram_req_sched #(
  parameter int                ADDR_W   = 24,
  parameter logic [9:0]        WR_BURST = 10'd256,
  parameter logic [9:0]        RD_BURST = 10'd256,
  parameter logic [ADDR_W-1:0] MIN_ADDR = '0,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 24'd1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sdram_init_done,
  input  logic [9:0]               wr_fifo_level,
  input  logic [9:0]               rd_fifo_room,
  input  logic                     rd_en,
  sdram_req_sched_if.master        sdram,
  output logic                     wr_fifo_rden,
  output logic                     rd_fifo_wren,
  output logic                     burst_err
);

  localparam logic [ADDR_W:0] WR_STEP = {{(ADDR_W-9){1'b0}}, WR_BURST};
  localparam logic [ADDR_W:0] RD_STEP = {{(ADDR_W-9){1'b0}}, RD_BURST};
  localparam logic [ADDR_W:0] MAX_EXT = {1'b0, MAX_ADDR};
  localparam logic [ADDR_W:0] REGION  = {1'b0, MAX_ADDR} - {1'b0, MIN_ADDR};

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER} state_e;

  state_e            state_q, state_d;
  logic              wr_req_q, wr_req_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   avail_q, avail_d;
  logic [9:0]        xfer_cnt_q, xfer_cnt_d;
  logic              err_q, err_d;
  logic              prio_rd_q, prio_rd_d;

  logic              wr_ack, rd_ack;
  logic              wr_elig, rd_elig;
  logic              in_wr, in_rd;
  logic              wr_done, rd_done;
  logic [ADDR_W:0]   wr_sum, rd_sum, avail_wr;

  assign wr_ack   = sdram.sdram_wr_ack;
  assign rd_ack   = sdram.sdram_rd_ack;
  assign wr_elig  = sdram_init_done && (wr_fifo_level >= WR_BURST);
  assign rd_elig  = sdram_init_done && rd_en && (rd_fifo_room >= RD_BURST) && (avail_q >= RD_STEP);
  assign in_wr    = (state_q == WR_REQ) || (state_q == WR_XFER);
  assign in_rd    = (state_q == RD_REQ) || (state_q == RD_XFER);
  assign wr_done  = (state_q == WR_XFER) && !wr_ack;
  assign rd_done  = (state_q == RD_XFER) && !rd_ack;
  assign wr_sum   = {1'b0, wr_addr_q} + WR_STEP;
  assign rd_sum   = {1'b0, rd_addr_q} + RD_STEP;
  assign avail_wr = avail_q + WR_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_addr_q  <= MIN_ADDR;
      rd_addr_q  <= MIN_ADDR;
      avail_q    <= '0;
      xfer_cnt_q <= '0;
      err_q      <= 1'b0;
      prio_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      avail_q    <= avail_d;
      xfer_cnt_q <= xfer_cnt_d;
      err_q      <= err_d;
      prio_rd_q  <= prio_rd_d;
    end
  end

  // When both directions are eligible, prio_rd_q picks the one not served last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_elig && (!rd_elig || !prio_rd_q)) state_d = WR_REQ;
        else if (rd_elig)                        state_d = RD_REQ;
      end
      WR_REQ:  if (wr_ack)  state_d = WR_XFER;
      WR_XFER: if (!wr_ack) state_d = IDLE;
      RD_REQ:  if (rd_ack)  state_d = RD_XFER;
      RD_XFER: if (!rd_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_req_d     = (state_d == WR_REQ);
    rd_req_d     = (state_d == RD_REQ);
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    avail_d      = avail_q;
    xfer_cnt_d   = xfer_cnt_q;
    err_d        = err_q;
    prio_rd_d    = prio_rd_q;
    wr_fifo_rden = wr_ack && in_wr;
    rd_fifo_wren = rd_ack && in_rd;

    // The acknowledge that ends a REQ state is the first word of the burst.
    case (state_q)
      WR_REQ:  if (wr_ack) xfer_cnt_d = 10'd1;
      RD_REQ:  if (rd_ack) xfer_cnt_d = 10'd1;
      WR_XFER: xfer_cnt_d = wr_ack ? xfer_cnt_q + 10'd1 : 10'd0;
      RD_XFER: xfer_cnt_d = rd_ack ? xfer_cnt_q + 10'd1 : 10'd0;
      default: xfer_cnt_d = 10'd0;
    endcase

    if (wr_done) begin
      if (xfer_cnt_q != WR_BURST) err_d = 1'b1;
      wr_addr_d = (wr_sum >= MAX_EXT) ? MIN_ADDR : wr_sum[ADDR_W-1:0];
      avail_d   = (avail_wr > REGION) ? REGION : avail_wr;
      prio_rd_d = 1'b1;
    end
    if (rd_done) begin
      if (xfer_cnt_q != RD_BURST) err_d = 1'b1;
      rd_addr_d = (rd_sum >= MAX_EXT) ? MIN_ADDR : rd_sum[ADDR_W-1:0];
      avail_d   = avail_q - RD_STEP;
      prio_rd_d = 1'b0;
    end

    // An acknowledge for the direction not in flight is dropped but flagged.
    if ((in_wr && rd_ack) || (in_rd && wr_ack)) err_d = 1'b1;
  end

  assign sdram.sdram_wr_req   = wr_req_q;
  assign sdram.sdram_rd_req   = rd_req_q;
  assign sdram.sdram_wr_burst = WR_BURST;
  assign sdram.sdram_rd_burst = RD_BURST;
  assign sdram.sdram_wr_addr  = wr_addr_q;
  assign sdram.sdram_rd_addr  = rd_addr_q;
  assign burst_err            = err_q;

endmodule

// File: tb/tb_sdram_req_sched.sv
// Self-checking bench for sdram_req_sched: the bench plays the SDRAM controller and tracks
// expected addresses, buffered word count, arbitration turn and error flag per burst.
module tb_sdram_req_sched;

  localparam int ADDR_W = 24;
  localparam int BURST  = 256;
  localparam int MINA   = 0;
  localparam int MAXA   = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_done;
  logic [9:0] wr_level;
  logic [9:0] rd_room;
  logic       rd_en_i;
  logic       wr_fifo_rden;
  logic       rd_fifo_wren;
  logic       burst_err;

  sdram_req_sched_if #(.ADDR_W(ADDR_W)) sdram ();

  sdram_req_sched #(
    .ADDR_W(ADDR_W), .WR_BURST(10'd256), .RD_BURST(10'd256),
    .MIN_ADDR(24'd0), .MAX_ADDR(24'd1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init_done),
    .wr_fifo_level(wr_level), .rd_fifo_room(rd_room), .rd_en(rd_en_i),
    .sdram(sdram), .wr_fifo_rden(wr_fifo_rden), .rd_fifo_wren(rd_fifo_wren),
    .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int oppStrobes = 0;
  int mWrAddr, mRdAddr, mAvail;
  bit mLastWrite, mErr;

  typedef struct {
    bit preWrite;
    bit init;
    int level;
    int room;
    bit ren;
    int expWr;
    int expRd;
  } vec_t;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit init, input int level, input int room, input bit ren);
    init_done = init;
    wr_level  = level[9:0];
    rd_room   = room[9:0];
    rd_en_i   = ren;
  endtask

  task automatic modelReset();
    mWrAddr    = MINA;
    mRdAddr    = MINA;
    mAvail     = 0;
    mLastWrite = 1'b0;
    mErr       = 1'b0;
  endtask

  task automatic doReset();
    sdram.sdram_wr_ack = 1'b0;
    sdram.sdram_rd_ack = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  // 0 = nothing, 1 = write, 2 = read, judged from the current inputs and the model state.
  function automatic int expDir();
    bit w, r;
    w = init_done && (wr_level >= BURST);
    r = init_done && rd_en_i && (rd_room >= BURST) && (mAvail >= BURST);
    if (w && r) return mLastWrite ? 2 : 1;
    if (w) return 1;
    if (r) return 2;
    return 0;
  endfunction

  // Waits one IDLE edge, then acts as controller for whatever burst the model predicts.
  task automatic runBurst(input int delay, input int nacks, input bit opp, output int seen);
    int dir;
    int strobes;
    dir = expDir();
    @(negedge clk);
    seen = sdram.sdram_wr_req ? 1 : (sdram.sdram_rd_req ? 2 : 0);
    checkOutput("req_dir", seen, dir);
    if (dir == 0 || seen != dir) return;
    checkOutput("addr_at_req", (dir == 1) ? sdram.sdram_wr_addr : sdram.sdram_rd_addr,
                (dir == 1) ? mWrAddr : mRdAddr);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checkOutput("req_hold", (dir == 1) ? sdram.sdram_wr_req : sdram.sdram_rd_req, 1);
    end
    strobes = 0;
    for (int i = 0; i < nacks; i++) begin
      if (dir == 1) sdram.sdram_wr_ack = 1'b1; else sdram.sdram_rd_ack = 1'b1;
      if (opp && i == nacks / 2) begin
        if (dir == 1) sdram.sdram_rd_ack = 1'b1; else sdram.sdram_wr_ack = 1'b1;
      end
      #1;
      if ((dir == 1) ? wr_fifo_rden : rd_fifo_wren) strobes++;
      if ((dir == 1) ? rd_fifo_wren : wr_fifo_rden) oppStrobes++;
      @(negedge clk);
      if (dir == 1) sdram.sdram_rd_ack = 1'b0; else sdram.sdram_wr_ack = 1'b0;
      if (i == 0) checkOutput("req_drop", (dir == 1) ? sdram.sdram_wr_req : sdram.sdram_rd_req, 0);
    end
    sdram.sdram_wr_ack = 1'b0;
    sdram.sdram_rd_ack = 1'b0;
    @(negedge clk);
    if (dir == 1) begin
      mWrAddr    = (mWrAddr + BURST >= MAXA) ? MINA : mWrAddr + BURST;
      mAvail     = (mAvail + BURST > MAXA - MINA) ? MAXA - MINA : mAvail + BURST;
      mLastWrite = 1'b1;
    end else begin
      mRdAddr    = (mRdAddr + BURST >= MAXA) ? MINA : mRdAddr + BURST;
      mAvail     = mAvail - BURST;
      mLastWrite = 1'b0;
    end
    if (nacks != BURST || opp) mErr = 1'b1;
    checkOutput("strobe_count", strobes, nacks);
    checkOutput("wr_addr_done", sdram.sdram_wr_addr, mWrAddr);
    checkOutput("rd_addr_done", sdram.sdram_rd_addr, mRdAddr);
    checkOutput("burst_err_done", burst_err, mErr);
    checkOutput("req_after_done", sdram.sdram_wr_req | sdram.sdram_rd_req, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    int   seen;
    int   expArb[4];
    int   expWrap[5];
    bit   anyReq;
    int   nacks, r;

    vecs[0] = '{0, 1, 256,  0,    0, 1, 0};
    vecs[1] = '{0, 1, 255,  0,    0, 0, 0};
    vecs[2] = '{0, 0, 511,  0,    0, 0, 0};
    vecs[3] = '{0, 1, 1023, 1023, 1, 1, 0};
    vecs[4] = '{0, 1, 0,    1023, 1, 0, 0};
    vecs[5] = '{1, 1, 0,    256,  1, 0, 1};
    vecs[6] = '{1, 1, 0,    255,  1, 0, 0};
    vecs[7] = '{1, 1, 0,    1023, 0, 0, 0};
    vecs[8] = '{1, 1, 300,  300,  1, 0, 1};
    vecs[9] = '{1, 0, 300,  300,  1, 0, 0};
    expArb  = '{2, 1, 2, 1};
    expWrap = '{256, 512, 768, 0, 256};

    // Reset values while reset is held.
    sdram.sdram_wr_ack = 1'b0;
    sdram.sdram_rd_ack = 1'b0;
    applyStimulus(1'b1, 1023, 1023, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_wr_req", sdram.sdram_wr_req, 0);
    checkOutput("rst_rd_req", sdram.sdram_rd_req, 0);
    checkOutput("rst_wr_addr", sdram.sdram_wr_addr, MINA);
    checkOutput("rst_rd_addr", sdram.sdram_rd_addr, MINA);
    checkOutput("rst_burst_err", burst_err, 0);
    checkOutput("wr_burst_const", sdram.sdram_wr_burst, BURST);
    checkOutput("rd_burst_const", sdram.sdram_rd_burst, BURST);

    for (int k = 0; k < 10; k++) begin
      doReset();
      if (vecs[k].preWrite) begin
        applyStimulus(1'b1, 256, 0, 1'b0);
        runBurst(0, BURST, 1'b0, seen);
      end
      applyStimulus(vecs[k].init, vecs[k].level, vecs[k].room, vecs[k].ren);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_wr_req", k), sdram.sdram_wr_req, vecs[k].expWr);
      checkOutput($sformatf("vec%0d_rd_req", k), sdram.sdram_rd_req, vecs[k].expRd);
    end

    doReset();
    applyStimulus(1'b1, 256, 0, 1'b0);
    runBurst(5, BURST, 1'b0, seen);
    checkOutput("single_wr_addr", sdram.sdram_wr_addr, 256);
    applyStimulus(1'b1, 0, 512, 1'b1);
    runBurst(2, BURST, 1'b0, seen);
    checkOutput("single_rd_dir", seen, 2);
    checkOutput("single_rd_addr", sdram.sdram_rd_addr, 256);
    @(negedge clk);
    checkOutput("avail_drained_rd_req", sdram.sdram_rd_req, 0);

    doReset();
    applyStimulus(1'b1, 256, 0, 1'b0);
    runBurst(0, BURST, 1'b0, seen);
    applyStimulus(1'b1, 1023, 1023, 1'b1);
    for (int k = 0; k < 4; k++) begin
      runBurst(k, BURST, 1'b0, seen);
      checkOutput($sformatf("arb_order%0d", k), seen, expArb[k]);
    end

    doReset();
    applyStimulus(1'b1, 1023, 0, 1'b0);
    checkOutput("wrap_start_addr", sdram.sdram_wr_addr, 0);
    for (int k = 0; k < 5; k++) begin
      runBurst(k % 3, BURST, 1'b0, seen);
      checkOutput($sformatf("wrap_wr_addr%0d", k), sdram.sdram_wr_addr, expWrap[k]);
      checkOutput($sformatf("wrap_rd_addr%0d", k), sdram.sdram_rd_addr, 0);
    end

    doReset();
    applyStimulus(1'b1, 256, 0, 1'b0);
    runBurst(2, BURST - 1, 1'b0, seen);
    checkOutput("short_burst_err", burst_err, 1);
    runBurst(0, BURST, 1'b0, seen);
    checkOutput("err_sticky", burst_err, 1);
    applyStimulus(1'b0, 511, 1023, 1'b1);
    anyReq = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (sdram.sdram_wr_req || sdram.sdram_rd_req) anyReq = 1'b1;
    end
    checkOutput("no_init_req", anyReq, 0);

    // Asynchronous reset on the 100th acknowledged word of a write burst.
    applyStimulus(1'b1, 256, 0, 1'b0);
    @(negedge clk);
    checkOutput("mid_req", sdram.sdram_wr_req, 1);
    for (int i = 0; i < 100; i++) begin
      sdram.sdram_wr_ack = 1'b1;
      if (i == 99) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_wr_req", sdram.sdram_wr_req, 0);
        checkOutput("async_rd_req", sdram.sdram_rd_req, 0);
        checkOutput("async_wr_addr", sdram.sdram_wr_addr, MINA);
        checkOutput("async_rd_addr", sdram.sdram_rd_addr, MINA);
        checkOutput("async_burst_err", burst_err, 0);
        checkOutput("async_rden", wr_fifo_rden, 0);
      end else begin
        @(negedge clk);
      end
    end
    sdram.sdram_wr_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    applyStimulus(1'b1, 256, 0, 1'b0);
    runBurst(1, BURST, 1'b0, seen);
    checkOutput("post_rst_dir", seen, 1);

    // Randomized traffic against the burst-level model, reset every few bursts.
    for (int it = 0; it < 48; it++) begin
      if (it % 8 == 0) doReset();
      r = int'($urandom % 8);
      nacks = (r == 0) ? BURST - 1 : ((r == 1) ? BURST + 1 : BURST);
      applyStimulus(($urandom % 8) != 0,
                    ($urandom % 2 != 0) ? int'($urandom_range(256, 1023)) : int'($urandom_range(0, 255)),
                    ($urandom % 2 != 0) ? int'($urandom_range(256, 1023)) : int'($urandom_range(0, 255)),
                    ($urandom % 4) != 0);
      runBurst(int'($urandom_range(0, 4)), nacks, ($urandom % 16) == 0, seen);
    end

    checkOutput("opposite_strobes", oppStrobes, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
